// File: rtl/freq_detect.sv
// freq_detect: hysteretic rising-zero-crossing pitch detector; averages 2^AVG_LOG2 periods, converts to Hz with a 24-step divider.
// freq_valid rises 26 clks after the completing crossing; no backpressure. Optional FREQ_DETECT_ROUND_EN rounds the quotient to nearest.
module freq_detect #(
  parameter int CLK_HZ     = 1000000,
  parameter int HYST       = 256,
  parameter int AVG_LOG2   = 2,
  parameter int MIN_PERIOD = 250,
  parameter int MAX_PERIOD = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_en,
  output logic [11:0] freq_out,
  output logic        freq_valid,
  output logic        locked,
  output logic        busy
);

  localparam int AW = 15 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  localparam logic [NW-1:0]       N_LAST   = NW'((1 << AVG_LOG2) - 1);
  localparam logic [23:0]         DIVIDEND = 24'(CLK_HZ << AVG_LOG2);
  localparam logic signed [15:0]  POS_TH   = 16'(HYST);
  localparam logic signed [15:0]  NEG_TH   = 16'(-HYST);
  localparam logic [14:0]         MIN_P    = 15'(MIN_PERIOD);
  localparam logic [14:0]         MAX_P    = 15'(MAX_PERIOD);

  localparam logic [1:0] SEEK = 2'd0;
  localparam logic [1:0] MEAS = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]         state;
  logic               armed;
  logic [14:0]        cnt;
  logic [AW-1:0]      acc;
  logic [NW-1:0]      n;

  logic [AW-1:0]      divisor;
  logic [AW-1:0]      rem;
  logic [23:0]        dvd_sr;
  logic [23:0]        quo;
  logic [4:0]         bit_cnt;
  logic               div_run;

  logic signed [15:0] smp;
  logic               is_low;
  logic               is_high;
  logic               evt;
  logic               accepted;
  logic               tmo;
  logic [14:0]        cnt_inc;
  logic [14:0]        cnt_nxt;
  logic [AW-1:0]      acc_sum;
  logic [23:0]        dividend_ld;
  logic [AW:0]        rem_sh;
  logic               rem_ge;
  logic [AW-1:0]      rem_sub;
  logic [11:0]        quo_sat;

  assign smp     = sample_in;
  assign is_low  = (smp <= NEG_TH);
  assign is_high = (smp >= POS_TH);
  assign evt     = sample_en && armed && is_high;

  // cnt_inc is the period of a crossing on this sample: it includes the event sample itself
  assign cnt_inc  = (cnt >= MAX_P) ? MAX_P : cnt + 15'd1;
  assign accepted = evt && ((state == SEEK) || (cnt_inc >= MIN_P));
  assign cnt_nxt  = !sample_en ? cnt : (accepted ? 15'd0 : cnt_inc);
  assign tmo      = (state == MEAS) && (cnt_nxt >= MAX_P);
  assign acc_sum  = acc + AW'(cnt_inc);

`ifdef FREQ_DETECT_ROUND_EN
  assign dividend_ld = DIVIDEND + 24'(divisor >> 1);
`else
  assign dividend_ld = DIVIDEND;
`endif

  // Restoring step; the true difference always fits AW bits, so the low bits are exact
  assign rem_sh  = {rem, dvd_sr[23]};
  assign rem_ge  = (rem_sh >= {1'b0, divisor});
  assign rem_sub = rem_sh[AW-1:0] - divisor;
  assign quo_sat = (quo > 24'd4095) ? 12'hFFF : quo[11:0];

  assign busy = div_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEEK;
      armed      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      n          <= '0;
      divisor    <= '0;
      rem        <= '0;
      dvd_sr     <= '0;
      quo        <= '0;
      bit_cnt    <= '0;
      div_run    <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      freq_valid <= 1'b0;

      if (sample_en) begin
        if (evt)
          armed <= 1'b0;
        else if (is_low)
          armed <= 1'b1;
      end
      cnt <= cnt_nxt;

      case (state)
        SEEK: begin
          if (accepted)
            state <= MEAS;
        end

        MEAS: begin
          if (accepted) begin
            if (n == N_LAST) begin
              divisor <= acc_sum;
              acc     <= '0;
              n       <= '0;
              state   <= DIV;
            end else begin
              acc <= acc_sum;
              n   <= n + NW'(1);
            end
          end else if (tmo) begin
            freq_out   <= '0;
            locked     <= 1'b0;
            freq_valid <= 1'b1;
            acc        <= '0;
            n          <= '0;
            state      <= SEEK;
          end
        end

        DIV: begin
          // First DIV cycle loads the dividend; the next 24 produce one quotient bit each
          if (!div_run) begin
            dvd_sr  <= dividend_ld;
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= '0;
            div_run <= 1'b1;
          end else begin
            dvd_sr  <= {dvd_sr[22:0], 1'b0};
            quo     <= {quo[22:0], rem_ge};
            rem     <= rem_ge ? rem_sub : rem_sh[AW-1:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              div_run <= 1'b0;
              state   <= OUT;
            end
          end
        end

        OUT: begin
          freq_out   <= quo_sat;
          locked     <= 1'b1;
          freq_valid <= 1'b1;
          state      <= MEAS;
        end

        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_detect.sv
// Directed bench for freq_detect: reset/seek vector table, then square-wave lock, glitch, timeout,
// low-amplitude, gated-sample and reset-during-divide sequences.
module tb_freq_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = 16'd0;
  logic        sample_en = 1'b0;
  logic [11:0] freq_out;
  logic        freq_valid;
  logic        locked;
  logic        busy;

`ifdef FREQ_DETECT_ROUND_EN
  localparam int EXP_HZ = 440;
`else
  localparam int EXP_HZ = 439;
`endif

  freq_detect dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .sample_en  (sample_en),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .locked     (locked),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;
  int pulse_cyc = 0;
  int pulse_fo = 0;
  int pulse_lk = 0;

  typedef struct {
    logic        r;
    logic [15:0] s;
    logic        en;
    logic [11:0] fo;
    logic        fv;
    logic        lk;
    logic        bz;
  } vec_t;

  vec_t vecs [8];

  task automatic step(input logic r, input logic [15:0] v, input logic en);
    @(negedge clk);
    rst       = r;
    sample_in = v;
    sample_en = en;
    @(posedge clk);
    #1;
    cyc++;
    if (freq_valid) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      pulse_fo  = int'(freq_out);
      pulse_lk  = int'(locked);
    end
    if (busy) busy_cnt++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sq(input int i, input int p, input int h);
    return ((i % p) < h) ? 16'hF801 : 16'h07FF;
  endfunction

  initial begin
    int e_cyc;
    int first_z, second_z, fo1, fo2, lk2, lk_pre;
    int found;
    logic [15:0] v;

    vecs[0] = '{1'b1, 16'h7FFF, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h8000, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'hF801, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h07FF, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h8000, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h7FFF, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'hF801, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 8; k++) begin
      step(vecs[k].r, vecs[k].s, vecs[k].en);
      check($sformatf("vec%0d_freq_out", k),   int'(freq_out),   int'(vecs[k].fo));
      check($sformatf("vec%0d_freq_valid", k), int'(freq_valid), int'(vecs[k].fv));
      check($sformatf("vec%0d_locked", k),     int'(locked),     int'(vecs[k].lk));
      check($sformatf("vec%0d_busy", k),       int'(busy),       int'(vecs[k].bz));
    end

    // Full-rate square, period 2273: seek crossing at 1137, fourth measured period ends at 10229
    step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    pulse_cnt = 0; busy_cnt = 0; pulse_cyc = 0; e_cyc = 0;
    for (int i = 0; i <= 10269; i++) begin
      step(1'b0, sq(i, 2273, 1137), 1'b1);
      if (i == 10229) e_cyc = cyc;
    end
    check("lock_pulses", pulse_cnt, 1);
    check("lock_latency", pulse_cyc - e_cyc, 26);
    check("lock_busy_clks", busy_cnt, 24);
    check("lock_freq", pulse_fo, EXP_HZ);
    check("lock_pulse_locked", pulse_lk, 1);
    check("lock_locked", int'(locked), 1);

    // Glitch 100 samples after the crossing at 12502, then averaging completes at 19321
    pulse_cnt = 0;
    for (int i = 10270; i <= 19321; i++) begin
      if (i == 12602)      v = 16'hF801;
      else if (i == 12603) v = 16'h07FF;
      else                 v = sq(i, 2273, 1137);
      step(1'b0, v, 1'b1);
    end
    check("glitch_no_early_pulse", pulse_cnt, 0);

    // Silence: the pending result lands at +26, the timeout at exactly 20000 samples
    pulse_cnt = 0; first_z = 0; second_z = 0; fo1 = -1; fo2 = -1; lk2 = -1; lk_pre = -1;
    for (int z = 1; z <= 20000; z++) begin
      step(1'b0, 16'd0, 1'b1);
      if (z == 19999) lk_pre = int'(locked);
      if (freq_valid) begin
        if (first_z == 0) begin
          first_z = z; fo1 = int'(freq_out);
        end else begin
          second_z = z; fo2 = int'(freq_out); lk2 = int'(locked);
        end
      end
    end
    check("glitch_pulse_pos", first_z, 26);
    check("glitch_freq", fo1, EXP_HZ);
    check("timeout_locked_before", lk_pre, 1);
    check("timeout_pulse_pos", second_z, 20000);
    check("timeout_freq", fo2, 0);
    check("timeout_locked", lk2, 0);
    check("timeout_pulses", pulse_cnt, 2);

    // Sub-threshold sine never arms the detector
    step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    pulse_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      int sv;
      sv = $rtoi(100.0 * $sin(2.0 * 3.14159265 * real'(i) / 2273.0));
      step(1'b0, 16'(sv), 1'b1);
    end
    check("sine_pulses", pulse_cnt, 0);
    check("sine_locked", int'(locked), 0);
    check("sine_freq", int'(freq_out), 0);

    // Half-rate enable; disabled cycles carry the inverted sample
    step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    pulse_cnt = 0; busy_cnt = 0; pulse_cyc = 0; e_cyc = 0;
    for (int i = 0; i <= 10259; i++) begin
      v = sq(i, 2273, 1137);
      step(1'b0, v, 1'b1);
      if (i == 10229) e_cyc = cyc;
      step(1'b0, ~v + 16'd1, 1'b0);
    end
    check("gated_pulses", pulse_cnt, 1);
    check("gated_latency", pulse_cyc - e_cyc, 26);
    check("gated_freq", pulse_fo, EXP_HZ);
    check("gated_busy_clks", busy_cnt, 24);

    // Short-period square to start another divide, then reset in the middle of it
    found = 0;
    for (int j = 0; j < 3000 && found == 0; j++) begin
      step(1'b0, sq(j, 300, 150), 1'b1);
      if (busy) found = 1;
    end
    check("divide_started", found, 1);
    for (int j = 0; j < 5; j++) step(1'b0, 16'h07FF, 1'b1);
    check("busy_before_rst", int'(busy), 1);
    check("locked_before_rst", int'(locked), 1);
    step(1'b1, 16'h07FF, 1'b1);
    check("rst_busy", int'(busy), 0);
    check("rst_freq", int'(freq_out), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_valid", int'(freq_valid), 0);
    pulse_cnt = 0; busy_cnt = 0;
    for (int j = 0; j < 35; j++) step(1'b0, 16'd0, 1'b1);
    check("rst_no_pulse", pulse_cnt, 0);
    check("rst_no_busy", busy_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
